// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES-128 decryption core, one inverse round per clock.
// The round keys are expanded on-chip into a small register file before decryption.
// Optional build macro AES_INV_KEY_REUSE_EN: keep the last expanded key and skip the
// expansion when the same key arrives again (10-edge latency instead of 20).

// Combinational AES S-box. INVERSE = 0 gives SubBytes, INVERSE = 1 gives InvSubBytes.
// Computed arithmetically (GF(2^8) inverse plus affine map) instead of a lookup table.
module aes_sbox #(
  parameter bit INVERSE = 1'b0
) (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] pw;
    logic [7:0] res;
    pw  = x;
    res = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      res = gf_mul(res, pw);
    end
    return res;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] dbl;
    dbl = {b, b} << n;
    return dbl[15:8];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
  endfunction

  // Pure lookup function of the input byte
  always_comb begin
    if (INVERSE) dout = gf_inv(inv_affine(din));
    else         dout = affine(gf_inv(din));
  end

endmodule

module aes_inv_cipher_iter #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [127:0]       ciphertext,
  input  logic [KEY_W-1:0]   key,
  output logic               busy,
  output logic               done,
  output logic [127:0]       plaintext
);

  // Only AES-128 is supported; anything else must fail at elaboration.
  generate
    if (NR != 10 || KEY_W != 128) begin : g_bad_cfg
      $error("aes_inv_cipher_iter supports only NR=10, KEY_W=128");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_KEXP = 2'd1;
  localparam logic [1:0] S_DEC  = 2'd2;

  localparam logic [3:0] RCNT_LAST = 4'(NR);
  localparam logic [3:0] RCNT_DEC0 = 4'(NR - 1);

  logic [1:0]   fsm_reg;
  logic [3:0]   rcnt_reg;
  logic [127:0] ct_reg;
  logic [127:0] state_reg;
  logic [127:0] kexp_reg;             // most recently expanded round key
  logic [127:0] rk_reg [0:NR];

`ifdef AES_INV_KEY_REUSE_EN
  logic         key_valid_reg;
  logic [127:0] last_key_reg;
  logic         key_hit;
  assign key_hit = key_valid_reg && (key == last_key_reg);
`endif

  genvar gi;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns on one column (byte 0 in bits [31:24])
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Round constant for producing round key idx (1..10)
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- key expansion step: rk[rcnt] from rk[rcnt-1] ----------------
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  w0, w1, w2, w3;
  logic [127:0] rk_next;

  assign rot_word = {kexp_reg[23:0], kexp_reg[31:24]};

  generate
    for (gi = 0; gi < 4; gi++) begin : g_ksbox
      aes_sbox #(.INVERSE(1'b0)) u_sbox (
        .din  (rot_word[8*gi +: 8]),
        .dout (sub_word[8*gi +: 8])
      );
    end
  endgenerate

  assign w0      = kexp_reg[127:96] ^ sub_word ^ {rcon(rcnt_reg), 24'h0};
  assign w1      = kexp_reg[95:64] ^ w0;
  assign w2      = kexp_reg[63:32] ^ w1;
  assign w3      = kexp_reg[31:0]  ^ w2;
  assign rk_next = {w0, w1, w2, w3};

  // ---------------- inverse round datapath ----------------
  logic [127:0] isr;   // after InvShiftRows
  logic [127:0] isb;   // after InvSubBytes
  logic [127:0] ark;   // after AddRoundKey
  logic [127:0] imc;   // after InvMixColumns

  // InvShiftRows rotates row r right by r: out(r,c) = in(r, c-r)
  generate
    for (gi = 0; gi < 16; gi++) begin : g_isr
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
      assign isr[127-8*gi -: 8] = state_reg[127-8*SRC -: 8];
      aes_sbox #(.INVERSE(1'b1)) u_isbox (
        .din  (isr[127-8*gi -: 8]),
        .dout (isb[127-8*gi -: 8])
      );
    end
  endgenerate

  assign ark = isb ^ rk_reg[rcnt_reg];

  generate
    for (gi = 0; gi < 4; gi++) begin : g_imc
      assign imc[127-32*gi -: 32] = inv_mix_col(ark[127-32*gi -: 32]);
    end
  endgenerate

  // Control FSM, key file writes, round state and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg   <= S_IDLE;
      rcnt_reg  <= 4'd0;
      ct_reg    <= '0;
      state_reg <= '0;
      kexp_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      plaintext <= '0;
      for (int i = 0; i <= NR; i++) rk_reg[i] <= '0;
`ifdef AES_INV_KEY_REUSE_EN
      key_valid_reg <= 1'b0;
      last_key_reg  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (fsm_reg)
        S_IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            ct_reg <= ciphertext;
`ifdef AES_INV_KEY_REUSE_EN
            if (key_hit) begin
              // Cached schedule is still valid: go straight to the rounds
              state_reg <= ciphertext ^ rk_reg[RCNT_LAST];
              rcnt_reg  <= RCNT_DEC0;
              fsm_reg   <= S_DEC;
            end else begin
              // The key file is about to be overwritten, so the cache is stale
              key_valid_reg <= 1'b0;
              last_key_reg  <= key;
              rk_reg[0]     <= key;
              kexp_reg      <= key;
              rcnt_reg      <= 4'd1;
              fsm_reg       <= S_KEXP;
            end
`else
            rk_reg[0] <= key;
            kexp_reg  <= key;
            rcnt_reg  <= 4'd1;
            fsm_reg   <= S_KEXP;
`endif
          end
        end
        S_KEXP: begin
          rk_reg[rcnt_reg] <= rk_next;
          kexp_reg         <= rk_next;
          if (rcnt_reg == RCNT_LAST) begin
            // Initial AddRoundKey uses the key being written this edge
            state_reg <= ct_reg ^ rk_next;
            rcnt_reg  <= RCNT_DEC0;
            fsm_reg   <= S_DEC;
`ifdef AES_INV_KEY_REUSE_EN
            key_valid_reg <= 1'b1;
`endif
          end else begin
            rcnt_reg <= rcnt_reg + 4'd1;
          end
        end
        S_DEC: begin
          if (rcnt_reg == 4'd0) begin
            // Final round has no InvMixColumns
            plaintext <= ark;
            done      <= 1'b1;
            busy      <= 1'b0;
            fsm_reg   <= S_IDLE;
          end else begin
            state_reg <= imc;
            rcnt_reg  <= rcnt_reg - 4'd1;
          end
        end
        default: fsm_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: directed + random checks of the iterative AES-128 decryptor.
// Expected plaintexts come from FIPS-197 vectors and from a forward AES-128 model
// (random plaintext encrypted here, then decrypted by the DUT).
// Build with AES_INV_KEY_REUSE_EN defined to exercise the key-cache latency.
module tb_aes_inv_cipher_iter;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [127:0] plaintext;

  int total = 0;
  int bad   = 0;

  // Bench-side key-cache tracking (only meaningful when the feature is built in)
  logic         mdl_kv = 1'b0;
  logic [127:0] mdl_key = '0;

  logic [7:0] sb [256];

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_inv_cipher_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ciphertext (ciphertext),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .plaintext  (plaintext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // busy and done must never be asserted together
  always @(negedge clk) begin
    if (rst_n === 1'b1) chk("busy_done_excl", {127'b0, busy & done}, 128'h0);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rot8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box built by walking the multiplicative group with generator 3
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rot8(q, 1) ^ rot8(q, 2) ^ rot8(q, 3) ^ rot8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] model_rk(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk;
    logic [127:0] res;
    rk = model_rk(k, 0);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      rk = model_rk(k, r);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Expected start-to-done edge count; updates the bench's view of the key cache
  function automatic int model_latency(input logic [127:0] k);
`ifdef AES_INV_KEY_REUSE_EN
    if (mdl_kv && k == mdl_key) return 10;
    mdl_kv  = 1'b1;
    mdl_key = k;
`endif
    return 20;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One decryption; poke > 0 pulses start (with junk vectors) so it is sampled at edge poke
  task automatic run_block(input string tag, input logic [127:0] c, input logic [127:0] k,
                           input logic [127:0] exp_pt, input int poke);
    int n;
    int exp_lat;
    exp_lat = model_latency(k);
    @(negedge clk);
    start = 1'b1; ciphertext = c; key = k;
    @(posedge clk); #1;
    start = 1'b0; ciphertext = rand128(); key = rand128();
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      chk({tag, "_busy"}, {127'b0, busy}, 128'h1);
      if (poke > 0 && n == poke - 1) begin
        start = 1'b1; ciphertext = rand128(); key = rand128();
      end
      @(posedge clk); #1;
      n++;
      start = 1'b0;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_pt"}, plaintext, exp_pt);
    chk({tag, "_busy_at_done"}, {127'b0, busy}, 128'h0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {127'b0, done}, 128'h0);
    chk({tag, "_pt_hold"}, plaintext, exp_pt);
    $display("txn %s ct=%h key=%h pt=%h edges=%0d", tag, c, k, plaintext, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp1, exp2;
    int dones;
    logic [127:0] rk_, rp;

    build_sbox();
    rst_n = 1'b0; start = 1'b0; ciphertext = '0; key = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {127'b0, busy}, 128'h0);
    chk("reset_done", {127'b0, done}, 128'h0);
    chk("reset_pt", plaintext, 128'h0);
    @(negedge clk); rst_n = 1'b1;

    // FIPS-197 C.1 and B
    run_block("fips_c1", C1, K1, P1, 0);
    run_block("fips_b", C2, K2, P2, 0);
    chk("fips_b_rk10", dut.rk_reg[10], RK2);

    // Start pulse while busy and inputs changed after acceptance
    run_block("ignore_start", C1, K1, P1, 5);

    // Reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; ciphertext = C2; key = K2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_busy_before", {127'b0, busy}, 128'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {127'b0, busy}, 128'h0);
    chk("abort_done", {127'b0, done}, 128'h0);
    chk("abort_pt", plaintext, 128'h0);
    mdl_kv = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_block("after_abort", C2, K2, P2, 0);

    // Same key twice, then a new key
    run_block("reuse_1", C2, K2, P2, 0);
    run_block("reuse_2", C1, K1, P1, 0);

    // Back-to-back with start held high
    exp1 = model_latency(K1);
    @(negedge clk);
    start = 1'b1; ciphertext = C1; key = K1;
    @(posedge clk); #1;
    ciphertext = C2; key = K2;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_lat1", n, exp1);
    chk("b2b_pt1", plaintext, P1);
    $display("txn b2b_1 pt=%h edges=%0d", plaintext, n);
    exp2 = model_latency(K2);
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) break;
      chk("b2b_pt_stable", plaintext, P1);
    end
    start = 1'b0;
    chk("b2b_gap", n, exp2 + 1);
    chk("b2b_pt2", plaintext, P2);
    $display("txn b2b_2 pt=%h gap=%0d", plaintext, n);
    @(posedge clk); #1;
    chk("b2b_done_pulse", {127'b0, done}, 128'h0);

    // Random plaintexts encrypted by the model, decrypted by the DUT
    rk_ = rand128();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) rk_ = rand128();
      rp = rand128();
      run_block("random", model_enc(rp, rk_), rk_, rp, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
